// File: rtl/hyperbus_burst_fifo.sv
// Burst adapter between valid/ready user queues (command, TX, RX) and a Hyperbus-style
// beat interface. User words are serialised MS-slice-first and reads are reassembled.
module hyperbus_burst_fifo #(
  parameter int USER_DATA_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH      = 32,
  parameter int CMD_DEPTH       = 4,
  parameter int DATA_DEPTH      = 16,
  parameter int MAX_BURST       = 8,
  localparam int LEN_WIDTH      = $clog2(MAX_BURST)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_we,
  input  logic [ADDR_WIDTH-1:0]      cmd_adr,
  input  logic [LEN_WIDTH-1:0]       cmd_len,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  input  logic [USER_DATA_WIDTH-1:0] tx_dat,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [USER_DATA_WIDTH-1:0] rx_dat,
  output logic [ADDR_WIDTH-1:0]      hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic                       hbus_rrq,
  output logic                       hbus_wrq,
  input  logic                       hbus_ready,
  input  logic                       hbus_valid,
  input  logic                       hbus_busy,
  output logic                       idle_o
);

  localparam int RATIO  = USER_DATA_WIDTH / HBUS_DATA_WIDTH;
  localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BCNT_W = $clog2(MAX_BURST * RATIO + 1);
  localparam int CPTR_W = $clog2(CMD_DEPTH);
  localparam int DPTR_W = $clog2(DATA_DEPTH);
  localparam int CCNT_W = $clog2(CMD_DEPTH + 1);
  localparam int DCNT_W = $clog2(DATA_DEPTH + 1);
  localparam int CMD_W  = 1 + ADDR_WIDTH + LEN_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                    state_q;
  logic                      wrq_q, rrq_q;
  logic [ADDR_WIDTH-1:0]     adr_q;
  logic [BCNT_W-1:0]         bcnt_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [USER_DATA_WIDTH-1:0] sr_q, sr_d;

  logic [CMD_W-1:0]           cmd_mem_q [CMD_DEPTH];
  logic [USER_DATA_WIDTH-1:0] tx_mem_q  [DATA_DEPTH];
  logic [USER_DATA_WIDTH-1:0] rx_mem_q  [DATA_DEPTH];
  logic [CPTR_W-1:0] cmd_wr_q, cmd_rd_q;
  logic [DPTR_W-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [CCNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [DCNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic                   cmd_push, cmd_pop, tx_push, tx_pop, rx_push, rx_pop;
  logic [CMD_W-1:0]       head;
  logic                   head_we;
  logic [ADDR_WIDTH-1:0]  head_adr;
  logic [LEN_WIDTH-1:0]   head_len;
  logic [DCNT_W-1:0]      need;
  logic                   launch_wr, launch_rd;
  logic                   wr_beat, rd_beat, last_slice, last_beat;
  logic [USER_DATA_WIDTH-1:0] tx_shift;

  assign cmd_ready = (cmd_cnt_q != CCNT_W'(CMD_DEPTH));
  assign tx_ready  = (tx_cnt_q != DCNT_W'(DATA_DEPTH));
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_dat    = rx_mem_q[rx_rd_q];

  assign cmd_push = cmd_valid && cmd_ready;
  assign tx_push  = tx_valid && tx_ready;
  assign rx_pop   = rx_valid && rx_ready;
  assign cmd_pop  = (state_q == DONE);

  assign head     = cmd_mem_q[cmd_rd_q];
  assign head_we  = head[CMD_W-1];
  assign head_adr = head[CMD_W-2 -: ADDR_WIDTH];
  assign head_len = head[LEN_WIDTH-1:0];
  assign need     = DCNT_W'(head_len) + DCNT_W'(1);

  // Launch only with the whole burst's data (write) or space (read) already in hand.
  assign launch_wr = (state_q == IDLE) && (cmd_cnt_q != '0) && head_we && !hbus_busy
                     && (tx_cnt_q >= need);
  assign launch_rd = (state_q == IDLE) && (cmd_cnt_q != '0) && !head_we && !hbus_busy
                     && ((DCNT_W'(DATA_DEPTH) - rx_cnt_q) >= need);

  assign wr_beat    = (state_q == WRITE) && hbus_ready;
  assign rd_beat    = (state_q == READ) && hbus_valid;
  assign last_slice = (beat_q == BEAT_W'(RATIO - 1));
  assign last_beat  = (bcnt_q == BCNT_W'(1));
  assign tx_pop     = wr_beat && last_slice;
  assign rx_push    = rd_beat && last_slice;

  assign tx_shift   = tx_mem_q[tx_rd_q] << (int'(beat_q) * HBUS_DATA_WIDTH);
  assign hbus_dat_o = (state_q == WRITE) ? tx_shift[USER_DATA_WIDTH-1 -: HBUS_DATA_WIDTH] : '0;
  assign hbus_adr_o = adr_q;
  assign hbus_wrq   = wrq_q;
  assign hbus_rrq   = rrq_q;
  assign idle_o     = (state_q == IDLE) && (cmd_cnt_q == '0);

  always_comb begin
    cmd_cnt_d = cmd_cnt_q + CCNT_W'(cmd_push) - CCNT_W'(cmd_pop);
    tx_cnt_d  = tx_cnt_q + DCNT_W'(tx_push) - DCNT_W'(tx_pop);
    rx_cnt_d  = rx_cnt_q + DCNT_W'(rx_push) - DCNT_W'(rx_pop);
    sr_d      = (sr_q << HBUS_DATA_WIDTH) | USER_DATA_WIDTH'(hbus_dat_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_wr_q  <= '0;
      cmd_rd_q  <= '0;
      cmd_cnt_q <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (cmd_push) cmd_wr_q <= cmd_wr_q + CPTR_W'(1);
      if (cmd_pop)  cmd_rd_q <= cmd_rd_q + CPTR_W'(1);
      if (tx_push)  tx_wr_q  <= tx_wr_q + DPTR_W'(1);
      if (tx_pop)   tx_rd_q  <= tx_rd_q + DPTR_W'(1);
      if (rx_push)  rx_wr_q  <= rx_wr_q + DPTR_W'(1);
      if (rx_pop)   rx_rd_q  <= rx_rd_q + DPTR_W'(1);
      cmd_cnt_q <= cmd_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage and read assembly carry no reset; occupancy counters qualify them.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_q] <= {cmd_we, cmd_adr, cmd_len};
    if (tx_push)  tx_mem_q[tx_wr_q]   <= tx_dat;
    if (rx_push)  rx_mem_q[rx_wr_q]   <= sr_d;
    if (rd_beat)  sr_q                <= sr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wrq_q   <= 1'b0;
      rrq_q   <= 1'b0;
      adr_q   <= '0;
      bcnt_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (launch_wr || launch_rd) begin
            state_q <= launch_wr ? WRITE : READ;
            wrq_q   <= launch_wr;
            rrq_q   <= launch_rd;
            adr_q   <= head_adr;
            bcnt_q  <= BCNT_W'(int'(need) * RATIO);
            beat_q  <= '0;
          end
        end
        WRITE, READ: begin
          if (wr_beat || rd_beat) begin
            bcnt_q <= bcnt_q - BCNT_W'(1);
            beat_q <= last_slice ? '0 : beat_q + BEAT_W'(1);
            if (last_beat) begin
              state_q <= DONE;
              wrq_q   <= 1'b0;
              rrq_q   <= 1'b0;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hyperbus_burst_fifo.md
HYPERBUS_BURST_FIFO -- requirements
Module: hyperbus_burst_fifo

Interface
REQ-001 SHALL have parameter USER_DATA_WIDTH, default 32: user-side data word width.
REQ-002 SHALL have parameter HBUS_DATA_WIDTH, default 16: Hyperbus native beat width; USER_DATA_WIDTH is an integer multiple of it, RATIO = USER_DATA_WIDTH/HBUS_DATA_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32: address width on both sides.
REQ-004 SHALL have parameter CMD_DEPTH, default 4 (power of 2): command queue entries.
REQ-005 SHALL have parameter DATA_DEPTH, default 16 (power of 2, >= MAX_BURST): TX and RX queue entries, in user words.
REQ-006 SHALL have parameter MAX_BURST, default 8 (power of 2): maximum user words per command; LEN_WIDTH = clog2(MAX_BURST).
REQ-007 Ports, clock and reset first:
 clk  in  1  single clock; one clock, reset is synchronous and active-high
 rst  in  1  synchronous active-high reset
 cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write, 0=read); cmd_adr in ADDR_WIDTH; cmd_len in LEN_WIDTH (words-1)
 tx_valid in 1; tx_ready out 1; tx_dat in USER_DATA_WIDTH
 rx_valid out 1; rx_ready in 1; rx_dat out USER_DATA_WIDTH
 hbus_adr_o out ADDR_WIDTH; hbus_dat_o out HBUS_DATA_WIDTH; hbus_dat_i in HBUS_DATA_WIDTH
 hbus_rrq out 1; hbus_wrq out 1; hbus_ready in 1; hbus_valid in 1; hbus_busy in 1
 idle_o out 1  high when in IDLE and command queue empty

Function
REQ-008 Every user port SHALL use valid/ready: transfer on the rising clk edge where both are high; valid never depends on ready.
REQ-009 cmd_ready, tx_ready SHALL be high iff the respective queue is not full; a push with a simultaneous pop on a full queue SHALL NOT be accepted.
REQ-010 rx_valid SHALL be high iff the RX queue is non-empty; rx_dat SHALL show the head entry, popped when rx_ready is high.
REQ-011 Queues SHALL be circular with pointer wrap at depth; simultaneous push and pop on a non-full, non-empty queue SHALL leave occupancy unchanged.
REQ-012 FSM states: IDLE, WRITE, READ, DONE.
REQ-013 IDLE -> WRITE when command head valid, cmd_we=1, hbus_busy=0, TX occupancy >= len+1.
REQ-014 IDLE -> READ when command head valid, cmd_we=0, hbus_busy=0, RX free space >= len+1.
REQ-015 On leaving IDLE: hbus_adr_o loads head address, beat counter loads (len+1)*RATIO, hbus_wrq or hbus_rrq asserts the next cycle.
REQ-016 hbus_rrq/hbus_wrq SHALL stay high through the burst and drop in the cycle after the final beat.
REQ-017 WRITE: a beat completes on hbus_ready=1; hbus_dat_o SHALL present the most-significant unsent HBUS_DATA_WIDTH slice of the current TX word; after RATIO beats the TX word is popped and the next loaded with no idle cycle.
REQ-018 READ: a beat completes on hbus_valid=1; hbus_dat_i SHALL shift in at the LSB end (first beat ends up most significant); after RATIO beats the assembled word is pushed to RX.
REQ-019 Beats with hbus_ready/hbus_valid low SHALL stall without state change.
REQ-020 Counter reaching 0 -> DONE; DONE pops the command queue, deasserts requests, -> IDLE; the next command SHALL NOT launch before the cycle after DONE.
REQ-021 hbus_adr_o SHALL stay constant for the whole burst.
REQ-022 hbus_valid in WRITE or IDLE, and hbus_ready in READ or IDLE, SHALL be ignored.
REQ-023 Commands SHALL execute strictly in acceptance order; TX data is consumed in acceptance order.

Reset
REQ-024 On rst=1 at a clk edge, including mid-burst: all queues empty, FSM IDLE, hbus_rrq=0, hbus_wrq=0, hbus_adr_o=0, hbus_dat_o=0, cmd_ready=1, tx_ready=1, rx_valid=0, idle_o=1 in the following cycle; in-flight data discarded.

Verification
REQ-025 Write len=0, adr=0x100, tx 0xAABBCCDD, hbus_ready=1 -> hbus_wrq 2 cycles, hbus_dat_o 0xAABB then 0xCCDD, hbus_adr_o=0x100.
REQ-026 Read len=3, adr=0x40, hbus_valid toggled 1/0, beats 0x0001..0x0008 -> 4 RX words 0x00010002, 0x00030004, 0x00050006, 0x00070008 in order; stalls hold state.
REQ-027 Write len=3 with only 2 TX words queued -> hbus_wrq stays 0 until 4th word accepted.
REQ-028 Push 4 commands with no drain (CMD_DEPTH=4) -> cmd_ready=0; 5th cmd_valid not accepted; simultaneous pop frees exactly one slot next cycle.
REQ-029 Read len=7 with rx_ready=0 and RX holding 9 words -> no launch; after 1 pop (free=8) burst starts.
REQ-030 rst asserted mid-write after 3 beats -> next cycle hbus_wrq=0, idle_o=1, tx_ready=1, no further hbus beats.
